// File: rtl/stm_pkg.sv
// Shared opcode encoding for the stm_multiphase accumulator and its ALU.
package stm_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'd0,
    OP_XOR  = 2'd1,
    OP_SUB  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

endpackage

// File: rtl/stm_alu.sv
// Combinational ALU for one accumulator step. Define STM_MULTIPHASE_SAT_EN for
// unsigned saturating ADD/SUB; otherwise ADD/SUB wrap modulo 2^WIDTH.
module stm_alu
  import stm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

`ifdef STM_MULTIPHASE_SAT_EN
  logic [WIDTH:0] sum_s;

  // Saturating opcode evaluation: carry-out clamps ADD high, borrow clamps SUB to zero
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  result = sum_s[WIDTH] ? '1 : sum_s[WIDTH-1:0];
      OP_XOR:  result = a ^ b;
      OP_SUB:  result = (a < b) ? '0 : (a - b);
      OP_PASS: result = b;
      default: result = b;
    endcase
  end
`else
  // Wrapping opcode evaluation
  always_comb begin
    case (op)
      OP_ADD:  result = a + b;
      OP_XOR:  result = a ^ b;
      OP_SUB:  result = a - b;
      OP_PASS: result = b;
      default: result = b;
    endcase
  end
`endif

endmodule

// File: rtl/stm_multiphase.sv
// N-phase cyclic accumulator with per-phase opcodes and valid/ready handshake.
// Saturating arithmetic is selected in stm_alu by STM_MULTIPHASE_SAT_EN.
module stm_multiphase
  import stm_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NPHASES = 4,
  parameter int PW      = $clog2(NPHASES)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*NPHASES-1:0] op_cfg,
  input  logic [PW:0]          nphases_act,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out,
  output logic [PW-1:0]        out_phase,
  output logic                 wrap
);

  logic [WIDTH-1:0] r_r;
  logic [PW-1:0]    st_r;
  logic             out_valid_r;
  logic             wrap_r;

  logic             xfer_s;
  logic [PW:0]      eff_n_s;
  logic [PW:0]      st_inc_s;
  logic [PW-1:0]    st_nxt_s;
  op_e              op_s;
  logic [WIDTH-1:0] alu_s;

  assign in_ready  = !out_valid_r || out_ready;
  assign xfer_s    = in_valid && in_ready;
  assign out       = r_r;
  assign out_phase = st_r;
  assign out_valid = out_valid_r;
  assign wrap      = wrap_r;

  // Clamp the live phase count to 1..NPHASES and compute the round-robin successor
  always_comb begin
    if (nphases_act == '0) begin
      eff_n_s = (PW+1)'(1);
    end else if (nphases_act > (PW+1)'(NPHASES)) begin
      eff_n_s = (PW+1)'(NPHASES);
    end else begin
      eff_n_s = nphases_act;
    end
    st_inc_s = {1'b0, st_r} + (PW+1)'(1);
    // A phase left stranded above a shrunk count still lands on 0 here
    if (st_inc_s >= eff_n_s) begin
      st_nxt_s = '0;
    end else begin
      st_nxt_s = st_inc_s[PW-1:0];
    end
    op_s = op_e'(op_cfg[{st_r, 1'b0} +: OP_W]);
  end

  stm_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (op_s),
    .a      (r_r),
    .b      (in),
    .result (alu_s)
  );

  // Accumulator, phase, output-valid and wrap registers; clear beats a same-edge transfer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_r         <= '0;
      st_r        <= '0;
      out_valid_r <= 1'b0;
      wrap_r      <= 1'b0;
    end else if (clear) begin
      r_r         <= '0;
      st_r        <= '0;
      out_valid_r <= 1'b0;
      wrap_r      <= 1'b0;
    end else if (xfer_s) begin
      r_r         <= alu_s;
      st_r        <= st_nxt_s;
      out_valid_r <= 1'b1;
      wrap_r      <= (st_nxt_s == '0);
    end else begin
      wrap_r <= 1'b0;
      if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_stm_multiphase.sv
// Scoreboard bench for stm_multiphase (WIDTH=8, NPHASES=4) with a high-level reference model.
module tb_stm_multiphase;

  localparam int W   = 8;
  localparam int NP  = 4;
  localparam int MOD = 256;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in;
  logic [7:0]   op_cfg;
  logic [2:0]   nphases_act;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [1:0]   out_phase;
  logic         wrap;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ph;
    logic       w;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_r, m_st, m_ov;

  stm_multiphase #(.WIDTH(W), .NPHASES(NP)) dut (
    .CLK(CLK), .RST_N(RST_N), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .op_cfg(op_cfg), .nphases_act(nphases_act),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_phase(out_phase), .wrap(wrap)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_op(input int op, input int a, input int b);
    case (op)
`ifdef STM_MULTIPHASE_SAT_EN
      0: return (a + b > MOD - 1) ? MOD - 1 : a + b;
      2: return (a < b) ? 0 : a - b;
`else
      0: return (a + b) % MOD;
      2: return (a - b + MOD) % MOD;
`endif
      1: return a ^ b;
      default: return b;
    endcase
  endfunction

  function automatic int eff_n(input int n);
    if (n == 0) return 1;
    if (n > NP) return NP;
    return n;
  endfunction

  // One clock of stimulus: starts and ends 1 time unit after a rising edge
  task automatic step(input bit iv, input logic [7:0] din, input bit clr, input bit ordy);
    bit xfer, exp_rdy;
    int op;
    in_valid = iv; in = din; clear = clr; out_ready = ordy;
    exp_rdy = (m_ov == 0) || ordy;
    @(negedge CLK);
    chk("in_ready", in_ready, exp_rdy);
    xfer = iv && exp_rdy && !clr;
    if (clr) begin
      m_r = 0; m_st = 0; m_ov = 0;
    end else if (xfer) begin
      op   = (op_cfg >> (2 * m_st)) & 3;
      m_r  = ref_op(op, m_r, din);
      m_st = (m_st + 1 >= eff_n(nphases_act)) ? 0 : m_st + 1;
      m_ov = 1;
      sb_q.push_back(exp_t'{d: m_r[7:0], ph: m_st[1:0], w: (m_st == 0)});
    end else if (m_ov != 0 && ordy) begin
      m_ov = 0;
    end
    @(posedge CLK); #1;
    if (!xfer) begin
      chk("hold_out", out, m_r);
      chk("hold_phase", out_phase, m_st);
      chk("hold_valid", out_valid, m_ov);
      chk("hold_wrap", wrap, 0);
    end
  endtask

  // Monitor: every accepted input must surface as the next scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      if (RST_N && in_valid && in_ready && !clear) begin
        @(negedge CLK);
        if (sb_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_underflow: got transfer, expected none at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("sb_out", out, e.d);
          chk("sb_phase", out_phase, e.ph);
          chk("sb_wrap", wrap, e.w);
          chk("sb_valid", out_valid, 1);
        end
      end
    end
  end

  initial begin
    logic [7:0] seq_in [4] = '{8'd5, 8'd3, 8'd2, 8'd9};
    logic [7:0] seq_out[4] = '{8'd5, 8'd6, 8'd4, 8'd9};
    logic [1:0] seq_ph [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    RST_N = 1'b0; clear = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b0;
    op_cfg = 8'b11_10_01_00; nphases_act = 3'd4;
    m_r = 0; m_st = 0; m_ov = 0;
    #3;
    chk("rst_out", out, 0);
    chk("rst_phase", out_phase, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_ready", in_ready, 1);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Sequencing: ADD, XOR, SUB, PASS
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq_in[i], 1'b0, 1'b1);
      chk("seq_out", out, seq_out[i]);
      chk("seq_phase", out_phase, seq_ph[i]);
      chk("seq_wrap", wrap, (i == 3));
    end

    // Backpressure
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b1, 8'd5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd3, 1'b0, 1'b0);
      chk("bp_ready", in_ready, 0);
      chk("bp_out", out, 5);
      chk("bp_phase", out_phase, 1);
    end
    step(1'b1, 8'd3, 1'b0, 1'b1);
    chk("bp_release", out, 6);

    // Arithmetic boundaries
    nphases_act = 3'd2;
    op_cfg = 8'b00_00_00_11;
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b1, 8'd250, 1'b0, 1'b1);
    step(1'b1, 8'd10, 1'b0, 1'b1);
`ifdef STM_MULTIPHASE_SAT_EN
    chk("add_boundary", out, 255);
`else
    chk("add_boundary", out, 4);
`endif
    op_cfg = 8'b00_00_10_11;
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b1, 8'd3, 1'b0, 1'b1);
    step(1'b1, 8'd5, 1'b0, 1'b1);
`ifdef STM_MULTIPHASE_SAT_EN
    chk("sub_boundary", out, 0);
`else
    chk("sub_boundary", out, 254);
`endif

    // Phase count 2, then 0, then shrink 4->2 while at phase 3
    op_cfg = 8'hFF;
    step(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, 1'b1);
      chk("n2_phase", out_phase, (i % 2 == 0) ? 1 : 0);
      chk("n2_wrap", wrap, (i % 2));
    end
    nphases_act = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(i + 7), 1'b0, 1'b1);
      chk("n0_phase", out_phase, 0);
      chk("n0_wrap", wrap, 1);
    end
    nphases_act = 3'd4;
    step(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd1, 1'b0, 1'b1);
    chk("shrink_pre", out_phase, 3);
    nphases_act = 3'd2;
    step(1'b1, 8'd2, 1'b0, 1'b1);
    chk("shrink_phase", out_phase, 0);
    chk("shrink_wrap", wrap, 1);

    // Clear priority at r=77, st=2
    nphases_act = 3'd4;
    step(1'b0, 8'd0, 1'b1, 1'b1);
    step(1'b1, 8'd77, 1'b0, 1'b1);
    step(1'b1, 8'd77, 1'b0, 1'b1);
    chk("clr_pre_out", out, 77);
    chk("clr_pre_phase", out_phase, 2);
    step(1'b1, 8'd99, 1'b1, 1'b1);
    chk("clr_out", out, 0);
    chk("clr_phase", out_phase, 0);
    chk("clr_valid", out_valid, 0);
    step(1'b1, 8'd5, 1'b0, 1'b1);
    chk("clr_next", out, 5);
    chk("clr_next_phase", out_phase, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        op_cfg = 8'($urandom);
        nphases_act = 3'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-cycle
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    step(1'b1, 8'd200, 1'b0, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_phase", out_phase, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_ready", in_ready, 1);
    m_r = 0; m_st = 0; m_ov = 0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    step(1'b0, 8'd0, 1'b0, 1'b1);

    repeat (2) @(posedge CLK);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
